// File: rtl/a0_trace_fifo_if.sv
// Handshake bundle between the a0 trace FIFO and its producer/sink.
// slave = FIFO side, master = CPU/sink side.
interface a0_trace_fifo_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_WIDTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                en;
  logic [WIDTH-1:0]    a0;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [TS_WIDTH-1:0] out_ts;
  logic [LW-1:0]       level;
  logic                overflow;
  logic [7:0]          drop_cnt;

  modport slave (
    input  en, a0, out_ready,
    output out_data, out_valid, out_ts, level, overflow, drop_cnt
  );

  modport master (
    output en, a0, out_ready,
    input  out_data, out_valid, out_ts, level, overflow, drop_cnt
  );
endinterface

// File: rtl/a0_trace_fifo.sv
// Samples the CPU a0 register, queues each change and streams it out over valid/ready.
// Define A0_TRACE_TIMESTAMP_EN to stamp every entry with a free-running cycle count.
module a0_trace_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  a0_trace_fifo_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic push_req, pop, full, push_ok, drop;

  always_comb begin
    push_req = bus.en && (bus.a0 != prev_q);
    pop      = (level_q != '0) && bus.out_ready;
    full     = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    prev_d = bus.en ? bus.a0 : prev_q;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = bus.a0;

    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hff)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
    end
  end

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem_d [DEPTH];

  always_comb begin
    ts_d     = ts_q + 1'b1;
    ts_mem_d = ts_mem_q;
    if (push_ok) ts_mem_d[wr_ptr_q] = ts_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
      for (int i = 0; i < DEPTH; i++) ts_mem_q[i] <= '0;
    end else begin
      ts_q     <= ts_d;
      ts_mem_q <= ts_mem_d;
    end
  end

  assign bus.out_ts = ts_mem_q[rd_ptr_q];
`else
  assign bus.out_ts = '0;
`endif

  // No bypass: the head is always read from storage.
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule
